// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage so memory, fetch and decode agree on widths.
// Also holds the fetch FSM state encoding.
package instruction_fetch_pkg;

    localparam int DEF_ADDR_W     = 8;
    localparam int DEF_INSTR_W    = 15;
    localparam int DEF_PROG_LEN   = 15;
    localparam int DEF_START_ADDR = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_pc_counter.sv
// Program counter for the fetch stage.
// Supports jump load, restart and increment, and flags the last program entry.
module instruction_fetch_pc_counter #(
    parameter int ADDR_W     = 8,
    parameter int PROG_LEN   = 15,
    parameter int START_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc,
    output logic              at_end,
    output logic              jump_legal
);

    localparam logic [ADDR_W-1:0] START = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(PROG_LEN - 1);
    localparam logic [ADDR_W-1:0] LEN   = ADDR_W'(PROG_LEN);

    assign at_end     = (pc == LAST);
    assign jump_legal = (jump_addr < LEN);

    // The last entry holds the pc so the address never leaves the program.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= START;
        end else if (jump) begin
            pc <= jump_addr;
        end else if (init) begin
            pc <= START;
        end else if (inc && !at_end) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch unit: walks the program counter through instruction memory and
// buffers one registered word for decode behind a valid/ready handshake.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_IDLE  | after reset, waiting for start; jumps ignored
//  S_FETCH | fetching one word per load opportunity
//  S_DONE  | end of program or illegal jump; buffer drains, start/jump honoured
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int INSTR_W    = DEF_INSTR_W,
    parameter int PROG_LEN   = DEF_PROG_LEN,
    parameter int START_ADDR = DEF_START_ADDR
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               jump_en,
    input  logic [ADDR_W-1:0]  jump_addr,
    output logic [ADDR_W-1:0]  address,
    input  logic [INSTR_W-1:0] mem_data,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               done,
    output logic               err
);

    fetch_state_e      state;
    logic [ADDR_W-1:0] pc;
    logic              load;
    logic              pc_jump;
    logic              pc_init;
    logic              pc_inc;
    logic              at_end;
    logic              jump_legal;

    assign load    = !instr_valid || instr_ready;
    assign pc_jump = jump_en && (state != S_IDLE);
    assign pc_init = start && ((state == S_IDLE) || (state == S_DONE));
    assign pc_inc  = (state == S_FETCH) && load && !jump_en;

    instruction_fetch_pc_counter #(
        .ADDR_W     (ADDR_W),
        .PROG_LEN   (PROG_LEN),
        .START_ADDR (START_ADDR)
    ) u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .init       (pc_init),
        .jump       (pc_jump),
        .jump_addr  (jump_addr),
        .inc        (pc_inc),
        .pc         (pc),
        .at_end     (at_end),
        .jump_legal (jump_legal)
    );

    assign address = pc;
    assign done    = (state == S_DONE) && !instr_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            instr_out   <= '0;
            pc_out      <= '0;
            instr_valid <= 1'b0;
            err         <= 1'b0;
        end else if (pc_jump) begin
            // Flush wins over a same-cycle handshake; decode still took that word.
            instr_valid <= 1'b0;
            if (jump_legal) begin
                state <= S_FETCH;
            end else begin
                state <= S_DONE;
                err   <= 1'b1;
            end
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_FETCH;
                        err   <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (load) begin
                        instr_out   <= mem_data;
                        pc_out      <= pc;
                        instr_valid <= 1'b1;
                        if (at_end) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state       <= S_FETCH;
                        err         <= 1'b0;
                        instr_valid <= 1'b0;
                    end else if (instr_valid && instr_ready) begin
                        instr_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: expected word streams are queued by
// the stimulus and consumed by a monitor on every valid/ready handshake.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    localparam int AW = DEF_ADDR_W;
    localparam int IW = DEF_INSTR_W;
    localparam int PL = DEF_PROG_LEN;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          jump_en;
    logic [AW-1:0] jump_addr;
    logic [AW-1:0] address;
    logic [IW-1:0] mem_data;
    logic [IW-1:0] instr_out;
    logic [AW-1:0] pc_out;
    logic          instr_valid;
    logic          instr_ready;
    logic          done;
    logic          err;

    instruction_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .address     (address),
        .mem_data    (mem_data),
        .instr_out   (instr_out),
        .pc_out      (pc_out),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [IW-1:0] mem_arr [PL];
    assign mem_data = (int'(address) < PL) ? mem_arr[int'(address)] : '0;

    typedef struct {
        int            pc;
        logic [IW-1:0] instr;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   exp_err = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference: a run from address a presents words a..PL-1 in order.
    task automatic push_run(input int from);
        for (int k = from; k < PL; k++) begin
            exp_t e;
            e.pc    = k;
            e.instr = mem_arr[k];
            q.push_back(e);
        end
    endtask

    // Monitor
    bit            hold_prev = 1'b0;
    logic [IW-1:0] prev_instr;
    logic [AW-1:0] prev_pc_out;
    logic [AW-1:0] prev_addr;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("err_flag", 32'(err), 32'(exp_err));
            if (hold_prev) begin
                check("stall_valid", 32'(instr_valid), 32'd1);
                check("stall_instr", 32'(instr_out), 32'(prev_instr));
                check("stall_pc_out", 32'(pc_out), 32'(prev_pc_out));
                check("stall_address", 32'(address), 32'(prev_addr));
            end
            if (instr_valid && !instr_ready) begin
                int nxt;
                nxt = int'(pc_out) + 1;
                if (nxt > PL - 1) nxt = PL - 1;
                check("stall_addr_next", 32'(address), 32'(nxt));
            end
            if (instr_valid && instr_ready) begin
                check("word_expected", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    check("word_pc", 32'(pc_out), 32'(e.pc));
                    check("word_instr", 32'(instr_out), 32'(e.instr));
                end
            end
            hold_prev   = instr_valid && !instr_ready && !jump_en && !start;
            prev_instr  = instr_out;
            prev_pc_out = pc_out;
            prev_addr   = address;
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start   = 1'b0;
        exp_err = 1'b0;
        q.delete();
        push_run(0);
    endtask

    task automatic wait_pc(input int target, input string nm);
        int n = 0;
        while (!(instr_valid && int'(pc_out) == target) && n < 60) begin
            step();
            n++;
        end
        check(nm, 32'(instr_valid && int'(pc_out) == target), 32'd1);
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!done && n < 200) begin
            step();
            n++;
        end
        check(nm, 32'(done), 32'd1);
        check({nm, "_drained"}, 32'(q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_valid"}, 32'(instr_valid), 32'd0);
        check({nm, "_instr"}, 32'(instr_out), 32'd0);
        check({nm, "_pc_out"}, 32'(pc_out), 32'd0);
        check({nm, "_done"}, 32'(done), 32'd0);
        check({nm, "_err"}, 32'(err), 32'd0);
        check({nm, "_address"}, 32'(address), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < PL; k++) mem_arr[k] = IW'($urandom);
        rst_n       = 1'b0;
        start       = 1'b1;
        jump_en     = 1'b0;
        jump_addr   = '0;
        instr_ready = 1'b0;

        // Reset held with start asserted
        step();
        step();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        start = 1'b0;
        step();
        check("idle_no_start_valid", 32'(instr_valid), 32'd0);

        // Streaming, ready always high: 15 back-to-back words
        instr_ready = 1'b1;
        do_start();
        begin
            int n = 0;
            @(negedge clk);
            while (!instr_valid && n < 5) begin
                @(negedge clk);
                n++;
            end
            check("start_first_word", 32'(instr_valid), 32'd1);
            for (int i = 0; i < PL; i++) begin
                check("stream_valid", 32'(instr_valid), 32'd1);
                check("stream_pc_seq", 32'(pc_out), 32'(i));
                @(negedge clk);
            end
            check("stream_end_valid", 32'(instr_valid), 32'd0);
            check("stream_end_done", 32'(done), 32'd1);
            check("stream_drained", 32'(q.size()), 32'd0);
        end
        step();

        // Backpressure at pc_out=3
        do_start();
        wait_pc(3, "bp_reach3");
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_instr", 32'(instr_out), 32'(mem_arr[3]));
            check("bp_pc_out", 32'(pc_out), 32'd3);
            check("bp_address", 32'(address), 32'd4);
        end
        instr_ready = 1'b1;
        step();
        check("bp_release_pc", 32'(pc_out), 32'd4);
        wait_done("bp_done");

        // Legal jump while pc_out=2
        do_start();
        wait_pc(2, "jmp_reach2");
        jump_en   = 1'b1;
        jump_addr = AW'(10);
        step();
        jump_en = 1'b0;
        q.delete();
        push_run(10);
        check("jmp_flush", 32'(instr_valid), 32'd0);
        step();
        check("jmp_target_valid", 32'(instr_valid), 32'd1);
        check("jmp_target_pc", 32'(pc_out), 32'd10);
        wait_done("jmp_done");

        // Illegal jump, then restart clears err
        do_start();
        wait_pc(5, "ill_reach5");
        jump_en   = 1'b1;
        jump_addr = AW'(20);
        step();
        jump_en = 1'b0;
        exp_err = 1'b1;
        q.delete();
        check("ill_err", 32'(err), 32'd1);
        check("ill_done", 32'(done), 32'd1);
        check("ill_valid", 32'(instr_valid), 32'd0);
        step();
        check("ill_err_sticky", 32'(err), 32'd1);
        do_start();
        check("ill_restart_err", 32'(err), 32'd0);
        step();
        check("ill_restart_pc", 32'(pc_out), 32'd0);
        check("ill_restart_valid", 32'(instr_valid), 32'd1);
        wait_done("ill_restart_done");

        // Reset mid-run at pc_out=7
        do_start();
        wait_pc(7, "rst_reach7");
        rst_n = 1'b0;
        step();
        q.delete();
        exp_err = 1'b0;
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        step();
        check("midreset_idle", 32'(instr_valid), 32'd0);

        // Randomized runs: random backpressure and occasional jumps
        for (int run = 0; run < 8; run++) begin
            int jumps = 0;
            instr_ready = 1'b1;
            do_start();
            for (int cyc = 0; cyc < 400; cyc++) begin
                bit do_jump;
                int tgt;
                instr_ready = ($urandom_range(0, 99) < 65);
                do_jump = (jumps < 3) && ($urandom_range(0, 99) < 6);
                tgt = $urandom_range(0, 20);
                if (do_jump) begin
                    jump_en   = 1'b1;
                    jump_addr = AW'(tgt);
                    jumps++;
                end
                step();
                if (do_jump) begin
                    jump_en = 1'b0;
                    q.delete();
                    if (tgt < PL) push_run(tgt);
                    else exp_err = 1'b1;
                end else if (done) begin
                    break;
                end
            end
            wait_done("rand_done");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
